// File: rtl/decode_queue.sv
// decode_queue: buffered RV32I decode stage between fetch and rename/dispatch.
// An IQ_DEPTH-entry instruction FIFO feeds a registered decoded output packet.
// The PC travels with the packet. Valid/ready handshakes on both sides.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   flush                 synchronous flush of FIFO and output packet
//   in_valid/in_ready     fetch handshake (in_ready = !full, combinational)
//   in_instr, in_pc       raw instruction word and its PC
//   out_valid/out_ready   consumer handshake
//   out_pc ... out_storeSize  registered decoded packet fields
//   out_illegal           illegal-instruction flag (only with DECODE_ILLEGAL_EN)
//   iq_count              FIFO occupancy, excluding the output register
//
// Build option: define DECODE_ILLEGAL_EN to add out_illegal and make
// R-type instructions with an unsupported funct7 decode with ctrl = 0.
module decode_queue #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IQ_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instr,
    input  logic [XLEN-1:0]               in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [6:0]                    out_opcode,
    output logic [2:0]                    out_funct3,
    output logic [6:0]                    out_funct7,
    output logic [4:0]                    out_rs1,
    output logic [4:0]                    out_rs2,
    output logic [4:0]                    out_rd,
    output logic [31:0]                   out_imm,
    output logic [6:0]                    out_ctrl,
    output logic [1:0]                    out_aluOp,
    output logic [1:0]                    out_lwSw,
    output logic                          out_storeSize,
`ifdef DECODE_ILLEGAL_EN
    output logic                          out_illegal,
`endif
    output logic [$clog2(IQ_DEPTH):0]     iq_count
);

    localparam int unsigned PW = $clog2(IQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // Decoded packet; ctrl = {hasImm,regWrite,aluSrc,branch,memRead,memWrite,memToReg}
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [6:0]  ctrl;
        logic [1:0]  alu_op;
        logic [1:0]  lw_sw;
        logic        store_size;
`ifdef DECODE_ILLEGAL_EN
        logic        illegal;
`endif
    } dec_t;

    logic [31:0]     iq_instr [IQ_DEPTH];
    logic [XLEN-1:0] iq_pc    [IQ_DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            full;
    logic            push;
    logic            load;
    logic [31:0]     hi;
    dec_t            dec;

    assign full     = (count == CW'(IQ_DEPTH));
    assign in_ready = !full;
    assign iq_count = count;
    // flush overrides both a push and a load in the same cycle
    assign push     = in_valid && !full && !flush;
    assign load     = (count != '0) && (!out_valid || out_ready) && !flush;
    assign hi       = iq_instr[head];

    // FIFO storage; no reset needed, occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            iq_instr[tail] <= in_instr;
            iq_pc[tail]    <= in_pc;
        end
    end

    // Pointers wrap naturally because IQ_DEPTH is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (load) head <= head + PW'(1);
            case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Decode of the FIFO head
    always_comb begin
        dec        = '0;
        dec.opcode = hi[6:0];
        dec.funct3 = hi[14:12];
        dec.funct7 = hi[31:25];
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = 1'b0;
`endif
        case (hi[6:0])
            OP_R: begin
                dec.ctrl   = 7'b0100000;
                dec.alu_op = 2'b10;
                dec.rs1    = hi[19:15];
                dec.rs2    = hi[24:20];
                dec.rd     = hi[11:7];
            end
            OP_I: begin
                dec.ctrl   = 7'b1110000;
                dec.alu_op = 2'b11;
                dec.rs1    = hi[19:15];
                dec.rd     = hi[11:7];
                dec.imm    = {{20{hi[31]}}, hi[31:20]};
            end
            OP_LD: begin
                dec.ctrl   = 7'b1110101;
                dec.lw_sw  = 2'b01;
                dec.rs1    = hi[19:15];
                dec.rd     = hi[11:7];
                dec.imm    = {{20{hi[31]}}, hi[31:20]};
            end
            OP_ST: begin
                dec.ctrl       = 7'b1010010;
                dec.lw_sw      = 2'b10;
                dec.rs1        = hi[19:15];
                dec.rs2        = hi[24:20];
                dec.imm        = {{20{hi[31]}}, hi[31:25], hi[11:7]};
                dec.store_size = (hi[14:12] == 3'b000);
            end
            OP_BR: begin
                dec.ctrl   = 7'b1001000;
                dec.alu_op = 2'b01;
                dec.rs1    = hi[19:15];
                dec.rs2    = hi[24:20];
                dec.imm    = {{19{hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
            end
            OP_LUI: begin
                dec.ctrl   = 7'b1110000;
                dec.alu_op = 2'b11;
                dec.rd     = hi[11:7];
                dec.imm    = {hi[31:12], 12'b0};
            end
            default: begin
`ifdef DECODE_ILLEGAL_EN
                dec.illegal = 1'b1;
`endif
            end
        endcase
        // Writes to x0 are architecturally dropped
        if (dec.rd == 5'd0) dec.ctrl[5] = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        // Only base-ISA funct7 encodings are legal for R-type
        if (hi[6:0] == OP_R && hi[31:25] != 7'b0000000 && hi[31:25] != 7'b0100000) begin
            dec.illegal = 1'b1;
            dec.ctrl    = 7'b0;
        end
`endif
    end

    // Output packet register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_opcode    <= '0;
            out_funct3    <= '0;
            out_funct7    <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_imm       <= '0;
            out_ctrl      <= '0;
            out_aluOp     <= '0;
            out_lwSw      <= '0;
            out_storeSize <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
            out_illegal   <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            out_pc        <= iq_pc[head];
            out_opcode    <= dec.opcode;
            out_funct3    <= dec.funct3;
            out_funct7    <= dec.funct7;
            out_rs1       <= dec.rs1;
            out_rs2       <= dec.rs2;
            out_rd        <= dec.rd;
            out_imm       <= dec.imm;
            out_ctrl      <= dec.ctrl;
            out_aluOp     <= dec.alu_op;
            out_lwSw      <= dec.lw_sw;
            out_storeSize <= dec.store_size;
`ifdef DECODE_ILLEGAL_EN
            out_illegal   <= dec.illegal;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: accepted pushes enqueue a reference
// decode, output handshakes pop and compare it field by field.
module tb_decode_queue;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IQ_DEPTH = 4;
    localparam int unsigned CW       = $clog2(IQ_DEPTH) + 1;

    logic            clk;
    logic            rstn;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [31:0]     out_imm;
    logic [6:0]      out_ctrl;
    logic [1:0]      out_aluOp;
    logic [1:0]      out_lwSw;
    logic            out_storeSize;
`ifdef DECODE_ILLEGAL_EN
    logic            out_illegal;
`endif
    logic [CW-1:0]   iq_count;

    decode_queue #(.XLEN(XLEN), .IQ_DEPTH(IQ_DEPTH)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_ctrl(out_ctrl), .out_aluOp(out_aluOp), .out_lwSw(out_lwSw),
        .out_storeSize(out_storeSize),
`ifdef DECODE_ILLEGAL_EN
        .out_illegal(out_illegal),
`endif
        .iq_count(iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [6:0]  ctrl;
        logic [1:0]  alu_op;
        logic [1:0]  lw_sw;
        logic        ss;
        logic        illegal;
    } exp_t;

    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    int          hs_cnt = 0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_pc;
    logic [31:0] hold_imm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference decode written straight from the opcode table
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic known;
        e        = '0;
        e.pc     = pc;
        e.opcode = i[6:0];
        e.funct3 = i[14:12];
        e.funct7 = i[31:25];
        known    = 1'b1;
        case (i[6:0])
            7'h33: begin e.ctrl = 7'b0100000; e.alu_op = 2'b10;
                         e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; end
            7'h13: begin e.ctrl = 7'b1110000; e.alu_op = 2'b11;
                         e.rs1 = i[19:15]; e.rd = i[11:7]; e.imm = 32'($signed(i[31:20])); end
            7'h03: begin e.ctrl = 7'b1110101; e.lw_sw = 2'b01;
                         e.rs1 = i[19:15]; e.rd = i[11:7]; e.imm = 32'($signed(i[31:20])); end
            7'h23: begin e.ctrl = 7'b1010010; e.lw_sw = 2'b10;
                         e.rs1 = i[19:15]; e.rs2 = i[24:20];
                         e.imm = 32'($signed({i[31:25], i[11:7]}));
                         e.ss = (i[14:12] == 3'd0); end
            7'h63: begin e.ctrl = 7'b1001000; e.alu_op = 2'b01;
                         e.rs1 = i[19:15]; e.rs2 = i[24:20];
                         e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h37: begin e.ctrl = 7'b1110000; e.alu_op = 2'b11;
                         e.rd = i[11:7]; e.imm = {i[31:12], 12'h000}; end
            default: known = 1'b0;
        endcase
        if (e.rd == 5'd0) e.ctrl[5] = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        e.illegal = !known;
        if (i[6:0] == 7'h33 && !(i[31:25] == 7'h00 || i[31:25] == 7'h20)) begin
            e.illegal = 1'b1;
            e.ctrl    = 7'b0;
        end
`endif
        return e;
    endfunction

    task automatic compare_pkt(input exp_t e);
        check("pc",     32'(out_pc),        e.pc);
        check("opcode", 32'(out_opcode),    32'(e.opcode));
        check("funct3", 32'(out_funct3),    32'(e.funct3));
        check("funct7", 32'(out_funct7),    32'(e.funct7));
        check("rs1",    32'(out_rs1),       32'(e.rs1));
        check("rs2",    32'(out_rs2),       32'(e.rs2));
        check("rd",     32'(out_rd),        32'(e.rd));
        check("imm",    out_imm,            e.imm);
        check("ctrl",   32'(out_ctrl),      32'(e.ctrl));
        check("aluop",  32'(out_aluOp),     32'(e.alu_op));
        check("lwsw",   32'(out_lwSw),      32'(e.lw_sw));
        check("ssize",  32'(out_storeSize), 32'(e.ss));
`ifdef DECODE_ILLEGAL_EN
        check("illegal", 32'(out_illegal), 32'(e.illegal));
`endif
    endtask

    // Scoreboard monitor, sampling mid-cycle
    always @(negedge clk) begin
        if (!rstn || flush) begin
            sb.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_pc",    out_pc,         hold_pc);
                check("hold_imm",   out_imm,        hold_imm);
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (sb.size() == 0) check("sb_nonempty_on_out", 32'(sb.size()), 32'd1);
                else                compare_pkt(sb.pop_front());
            end
            hold_v   = out_valid && !out_ready;
            hold_pc  = out_pc;
            hold_imm = out_imm;
            if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
        end
    end

    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 32'(sb.size()) + 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  ops [8];
        logic [31:0] r;
        logic        done;
        int          h0;
        logic        acc;

        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h7F, 7'h6F};
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_iq_count",  32'(iq_count),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_imm",   out_imm,        32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // addi x5,x1,-3: valid one edge after acceptance
        push(32'hFFD08293, 32'h100);
        check("addi_latency_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_rd",    32'(out_rd),    32'd5);
        check("addi_rs1",   32'(out_rs1),   32'd1);
        check("addi_rs2",   32'(out_rs2),   32'd0);
        check("addi_imm",   out_imm,        32'hFFFFFFFD);
        check("addi_ctrl",  32'(out_ctrl),  32'b1110000);
        check("addi_aluop", 32'(out_aluOp), 32'b11);
        check("addi_pc",    out_pc,         32'h100);
        drain(20);

        // sb x2,4(x3)
        push(32'h00218223, 32'h104);
        @(posedge clk); #1;
        check("sb_rd",    32'(out_rd),        32'd0);
        check("sb_rs1",   32'(out_rs1),       32'd3);
        check("sb_rs2",   32'(out_rs2),       32'd2);
        check("sb_imm",   out_imm,            32'd4);
        check("sb_ctrl",  32'(out_ctrl),      32'b1010010);
        check("sb_lwsw",  32'(out_lwSw),      32'b10);
        check("sb_ssize", 32'(out_storeSize), 32'd1);
        drain(20);

        // x0 destination, unknown opcode, non-base R-type funct7
        push(32'h00208033, 32'h300);
        @(posedge clk); #1;
        check("addx0_ctrl", 32'(out_ctrl), 32'd0);
        check("addx0_rs2",  32'(out_rs2),  32'd2);
        push(32'h0000007F, 32'h304);
        @(posedge clk); #1;
        check("unk_ctrl", 32'(out_ctrl), 32'd0);
`ifdef DECODE_ILLEGAL_EN
        check("unk_illegal", 32'(out_illegal), 32'd1);
`endif
        push(32'h022081B3, 32'h308);
        @(posedge clk); #1;
`ifdef DECODE_ILLEGAL_EN
        check("mulf7_ctrl",    32'(out_ctrl),    32'd0);
        check("mulf7_illegal", 32'(out_illegal), 32'd1);
`else
        check("mulf7_ctrl", 32'(out_ctrl), 32'b0100000);
`endif
        drain(20);

        // Backpressure: fill output + FIFO, then release
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(32'h00100093 + (32'(k) << 20), 32'h400 + 32'(k) * 4);
        in_valid = 1'b1; in_instr = 32'h00600093; in_pc = 32'h414;
        @(posedge clk); #1;
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_iq_count",  32'(iq_count),  32'd4);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_pc",    out_pc,         32'h400);
        out_ready = 1'b1;
        h0 = hs_cnt;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        check("bp_handshakes", 32'(hs_cnt - h0), 32'd6);
        check("bp_empty_valid", 32'(out_valid), 32'd0);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Flush with a concurrent push
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(32'h00000013, 32'h500 + 32'(k) * 4);
        check("fl_pre_count", 32'(iq_count), 32'd3);
        in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'hDEAD0000; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_iq_count",  32'(iq_count),  32'd0);
        check("fl_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        h0 = hs_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("fl_no_reappear", 32'(hs_cnt - h0), 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(32'hFFD08293, 32'h600 + 32'(k) * 4);
        #2;
        rstn = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_iq_count",  32'(iq_count),  32'd0);
        check("mr_in_ready",  32'(in_ready),  32'd1);
        check("mr_out_pc",    out_pc,         32'd0);
        check("mr_out_imm",   out_imm,        32'd0);
        check("mr_out_ctrl",  32'(out_ctrl),  32'd0);
        @(posedge clk); #1;
        rstn = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("mr_still_empty", 32'(out_valid), 32'd0);

        // Random stream under random backpressure
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    r = $urandom();
                    push({r[31:7], ops[$urandom_range(0, 7)]}, 32'h1000 + 32'(k) * 4);
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
